bp_fe_bht_update_queue: RTL and testbench
=========================================

// Module: bp_fe_bht_update_queue
// PURPOSE
//  In-order queue of outstanding BHT predictions. It sits directly upstream of the BHT write port.
//  At fetch, each predicted branch pushes {bht idx, predicted direction}.
//  When the backend resolves branches in program order, the head entry is popped.
//  The queue then drives one registered BHT update per resolution: w_v, idx_w, correct, pred_taken.
// PARAMETERS
//  bht_idx_width_p  9  BHT index width; must match the BHT instance
//  els_p            8  queue depth; power of 2, >=2
// PORTS
//  clk_i            in   1                 clock
//  reset_n_i        in   1                 synchronous, active-low reset
//  push_v_i         in   1                 prediction made this cycle
//  push_idx_i       in   bht_idx_width_p   BHT index used for the prediction
//  push_taken_i     in   1                 predicted direction (1 = taken)
//  push_ready_o     out  1                 queue can accept a push
//  resolve_v_i      in   1                 oldest outstanding branch resolved
//  resolve_taken_i  in   1                 actual direction
//  flush_i          in   1                 squash all outstanding predictions
//  w_v_o            out  1                 BHT write valid
//  idx_w_o          out  bht_idx_width_p   BHT write index
//  correct_o        out  1                 prediction matched the outcome
//  pred_taken_o     out  1                 direction that was predicted
//  count_o          out  $clog2(els_p)+1   occupancy
//  resolve_err_o    out  1                 pulse: resolve arrived while the queue was empty
// BEHAVIOUR
//  - Storage: circular buffer of els_p x {idx, taken}.
//    - rd/wr pointers are $clog2(els_p) bits and wrap naturally.
//    - count is $clog2(els_p)+1 bits.
//  - Reset (reset_n_i==0 at a clk edge):
//    - Pointers, count, w_v_o, idx_w_o, correct_o, pred_taken_o and resolve_err_o all go to 0.
//    - push_ready_o is 1 out of reset.
//    - Storage contents are don't-care.
//    - Reset wins over every other input in the same cycle.
//  - push_ready_o = (count != els_p). It is combinational from state only.
//    - A push is accepted iff push_v_i & push_ready_o.
//    - push_v_i while full is dropped; state is unchanged.
//  - A pop happens iff resolve_v_i & (count != 0).
//    - The pop reads the head entry and advances rd_ptr.
//  - Update output, registered with 1-cycle latency:
//    - A pop in cycle N makes w_v_o=1 in cycle N+1.
//    - In N+1: idx_w_o = head idx, pred_taken_o = head taken, correct_o = (head taken == resolve_taken_i).
//    - With no pop, w_v_o=0 next cycle. idx_w_o, correct_o and pred_taken_o hold their previous values.
//  - resolve_v_i while count==0:
//    - No pop and no update.
//    - resolve_err_o=1 in the next cycle, for one cycle only.
//  - Push and pop in the same cycle (count>0): both occur and count is unchanged.
//    - A push into an empty queue cannot be popped in that same cycle. The resolve is treated as the error case above.
//  - Push and pop while full: the push is rejected because ready is 0. The pop proceeds and count decrements.
//  - flush_i=1:
//    - A same-cycle pop completes first, so its update still issues in N+1.
//    - Then all remaining entries are discarded: wr_ptr = rd_ptr after the pop, count = 0.
//    - A same-cycle push is discarded.
//  - flush_i has no effect on an update already registered on w_v_o.
//  - Outputs never depend combinationally on push or resolve inputs, except push_ready_o, which depends on state only.
// TESTING
//  - Reset: hold reset_n_i=0 for 2 cycles.
//    -> count_o=0, w_v_o=0, push_ready_o=1, resolve_err_o=0.
//  - Basic update: push idx=0x05/taken=1, next cycle resolve taken=0.
//    -> the following cycle w_v_o=1, idx_w_o=0x05, pred_taken_o=1, correct_o=0, count_o=0.
//  - Fill and wrap:
//    - Push 8 entries idx 0..7. -> push_ready_o=0, count_o=8.
//    - A 9th push is dropped.
//    - Resolve 8 times. -> updates come out in order idx 0..7.
//    - Push idx 8, then resolve. -> idx_w_o=8 (pointer wrap correct).
//  - Simultaneous push and pop with count=3, 5 cycles back to back.
//    -> count_o stays 3 and updates emerge strictly in FIFO order.
//  - Flush with pop, count=4 (idx A,B,C,D): assert flush_i+resolve_v_i+push_v_i together.
//    -> next cycle w_v_o=1 with idx A, count_o=0, the pushed entry is not retained.
//  - Empty resolve: resolve_v_i with count=0.
//    -> w_v_o=0 and resolve_err_o=1 for exactly one cycle. count_o stays 0.

Source files
------------

// File: rtl/bp_fe_bht_update_queue_if.sv
// bp_fe_bht_update_queue_if: fetch/backend-facing bundle of the BHT update queue.
//   push_v_i/push_idx_i/push_taken_i -> push_ready_o : predictions entering at fetch
//   resolve_v_i/resolve_taken_i, flush_i             : in-order resolutions and squash
//   w_v_o/idx_w_o/correct_o/pred_taken_o             : registered BHT write port
//   count_o, resolve_err_o                           : occupancy and empty-resolve pulse
interface bp_fe_bht_update_queue_if #(
    parameter int bht_idx_width_p = 9,
    parameter int els_p           = 8
);
    logic                       push_v_i;
    logic [bht_idx_width_p-1:0] push_idx_i;
    logic                       push_taken_i;
    logic                       push_ready_o;
    logic                       resolve_v_i;
    logic                       resolve_taken_i;
    logic                       flush_i;
    logic                       w_v_o;
    logic [bht_idx_width_p-1:0] idx_w_o;
    logic                       correct_o;
    logic                       pred_taken_o;
    logic [$clog2(els_p):0]     count_o;
    logic                       resolve_err_o;
    modport master (
        output push_v_i, push_idx_i, push_taken_i, resolve_v_i, resolve_taken_i, flush_i,
        input  push_ready_o, w_v_o, idx_w_o, correct_o, pred_taken_o, count_o, resolve_err_o
    );
    modport slave (
        input  push_v_i, push_idx_i, push_taken_i, resolve_v_i, resolve_taken_i, flush_i,
        output push_ready_o, w_v_o, idx_w_o, correct_o, pred_taken_o, count_o, resolve_err_o
    );
endinterface

// File: rtl/bp_fe_bht_update_queue.sv
// bp_fe_bht_update_queue: in-order queue of outstanding BHT predictions feeding the BHT write port.
//   clk_i      : clock
//   reset_n_i  : synchronous active-low reset
//   bus        : slave side of bp_fe_bht_update_queue_if (push, resolve, flush, update, status)
module bp_fe_bht_update_queue #(
    parameter int bht_idx_width_p = 9,
    parameter int els_p           = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    bp_fe_bht_update_queue_if.slave   bus
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = ptr_w + 1;
    logic [bht_idx_width_p:0]   r_mem [els_p];
    logic [ptr_w-1:0]           r_rd_ptr, r_wr_ptr;
    logic [cnt_w-1:0]           r_count;
    logic                       r_w_v, r_correct, r_pred_taken, r_err;
    logic [bht_idx_width_p-1:0] r_idx_w;
    logic                       w_push, w_pop, w_empty;
    logic [bht_idx_width_p:0]   w_head;
    logic [ptr_w-1:0]           w_rd_next;
    always_comb begin
        w_empty   = r_count == '0;
        w_push    = bus.push_v_i & bus.push_ready_o;
        w_pop     = bus.resolve_v_i & ~w_empty;
        w_head    = r_mem[r_rd_ptr];
        w_rd_next = r_rd_ptr + ptr_w'(w_pop);
    end
    assign bus.push_ready_o  = r_count != cnt_w'(els_p);
    assign bus.count_o       = r_count;
    assign bus.w_v_o         = r_w_v;
    assign bus.idx_w_o       = r_idx_w;
    assign bus.correct_o     = r_correct;
    assign bus.pred_taken_o  = r_pred_taken;
    assign bus.resolve_err_o = r_err;
    // Storage is not reset; a flushed push is never written.
    always_ff @(posedge clk_i) begin
        if (w_push & ~bus.flush_i)
            r_mem[r_wr_ptr] <= {bus.push_idx_i, bus.push_taken_i};
    end
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_w_v        <= 1'b0;
            r_idx_w      <= '0;
            r_correct    <= 1'b0;
            r_pred_taken <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rd_ptr <= w_rd_next;
            // Flush lets the same-cycle pop retire, then empties the queue behind it.
            r_wr_ptr <= bus.flush_i ? w_rd_next : r_wr_ptr + ptr_w'(w_push);
            r_count  <= bus.flush_i ? '0 : r_count + cnt_w'(w_push) - cnt_w'(w_pop);
            r_w_v    <= w_pop;
            r_err    <= bus.resolve_v_i & w_empty;
            if (w_pop) begin
                r_idx_w      <= w_head[bht_idx_width_p:1];
                r_pred_taken <= w_head[0];
                r_correct    <= w_head[0] == bus.resolve_taken_i;
            end
        end
    end
endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// tb_bp_fe_bht_update_queue: directed bench with a queue-based reference model checked every cycle.
module tb_bp_fe_bht_update_queue;
    localparam int iw = 9;
    localparam int n  = 8;
    logic clk_i = 1'b0;
    logic reset_n_i;
    int total = 0;
    int bad   = 0;
    bp_fe_bht_update_queue_if #(.bht_idx_width_p(iw), .els_p(n)) bus ();
    bp_fe_bht_update_queue #(.bht_idx_width_p(iw), .els_p(n)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus)
    );
    always #5 clk_i = ~clk_i;
    logic [iw:0] q [$];
    logic          e_wv, e_corr, e_pred, e_err;
    logic [iw-1:0] e_idx;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic drv(input logic pv, input logic [iw-1:0] pi, input logic pt,
                       input logic rv, input logic rt, input logic fl);
        bus.push_v_i = pv; bus.push_idx_i = pi; bus.push_taken_i = pt;
        bus.resolve_v_i = rv; bus.resolve_taken_i = rt; bus.flush_i = fl;
    endtask
    task automatic cyc();
        int sz;
        logic [iw:0] h;
        sz = q.size();
        if (!reset_n_i) begin
            q.delete();
            {e_wv, e_idx, e_corr, e_pred, e_err} = '0;
        end else begin
            e_err = bus.resolve_v_i && sz == 0;
            e_wv  = bus.resolve_v_i && sz != 0;
            if (e_wv) begin
                h = q.pop_front();
                e_idx = h[iw:1]; e_pred = h[0]; e_corr = h[0] == bus.resolve_taken_i;
            end
            if (bus.flush_i) q.delete();
            else if (bus.push_v_i && sz != n) q.push_back({bus.push_idx_i, bus.push_taken_i});
        end
        @(posedge clk_i);
        #1;
        check("count", 32'(bus.count_o), 32'(q.size()));
        check("ready", 32'(bus.push_ready_o), 32'(q.size() != n));
        check("w_v", 32'(bus.w_v_o), 32'(e_wv));
        check("idx_w", 32'(bus.idx_w_o), 32'(e_idx));
        check("pred", 32'(bus.pred_taken_o), 32'(e_pred));
        check("correct", 32'(bus.correct_o), 32'(e_corr));
        check("err", 32'(bus.resolve_err_o), 32'(e_err));
    endtask
    initial begin
        reset_n_i = 1'b0;
        drv(1, 9'h33, 1, 1, 0, 0);
        cyc(); cyc();
        check("rst_count", 32'(bus.count_o), 0);
        check("rst_wv", 32'(bus.w_v_o), 0);
        check("rst_ready", 32'(bus.push_ready_o), 1);
        check("rst_err", 32'(bus.resolve_err_o), 0);
        reset_n_i = 1'b1;
        drv(1, 9'h05, 1, 0, 0, 0); cyc();
        drv(0, 0, 0, 1, 0, 0); cyc();
        check("basic_wv", 32'(bus.w_v_o), 1);
        check("basic_idx", 32'(bus.idx_w_o), 32'h05);
        check("basic_pred", 32'(bus.pred_taken_o), 1);
        check("basic_corr", 32'(bus.correct_o), 0);
        check("basic_count", 32'(bus.count_o), 0);
        drv(0, 0, 0, 0, 0, 0); cyc();
        check("hold_idx", 32'(bus.idx_w_o), 32'h05);
        for (int i = 0; i < n; i++) begin drv(1, iw'(i), i[0], 0, 0, 0); cyc(); end
        check("full_ready", 32'(bus.push_ready_o), 0);
        check("full_count", 32'(bus.count_o), 8);
        drv(1, 9'h1ff, 1, 0, 0, 0); cyc();
        check("drop_count", 32'(bus.count_o), 8);
        for (int i = 0; i < n; i++) begin
            drv(0, 0, 0, 1, 1, 0); cyc();
            check("drain_idx", 32'(bus.idx_w_o), 32'(i));
            check("drain_corr", 32'(bus.correct_o), 32'(i[0]));
        end
        drv(1, 9'd8, 0, 0, 0, 0); cyc();
        drv(0, 0, 0, 1, 0, 0); cyc();
        check("wrap_idx", 32'(bus.idx_w_o), 8);
        check("wrap_corr", 32'(bus.correct_o), 1);
        for (int i = 0; i < 3; i++) begin drv(1, iw'(10 + i), 1, 0, 0, 0); cyc(); end
        for (int k = 0; k < 5; k++) begin
            drv(1, iw'(20 + k), 0, 1, 1, 0); cyc();
            check("pp_count", 32'(bus.count_o), 3);
            check("pp_idx", 32'(bus.idx_w_o), 32'(k < 3 ? 10 + k : 17 + k));
        end
        for (int i = 0; i < 3; i++) begin drv(0, 0, 0, 1, 0, 0); cyc(); end
        for (int i = 0; i < 4; i++) begin drv(1, iw'(10 + i), 1, 0, 0, 0); cyc(); end
        drv(1, 9'h1ee, 1, 1, 1, 1); cyc();
        check("flush_wv", 32'(bus.w_v_o), 1);
        check("flush_idx", 32'(bus.idx_w_o), 32'h0a);
        check("flush_count", 32'(bus.count_o), 0);
        drv(0, 0, 0, 1, 0, 0); cyc();
        check("empty_err", 32'(bus.resolve_err_o), 1);
        check("empty_wv", 32'(bus.w_v_o), 0);
        check("empty_count", 32'(bus.count_o), 0);
        drv(0, 0, 0, 0, 0, 0); cyc();
        check("err_pulse", 32'(bus.resolve_err_o), 0);
        drv(1, 9'h07, 0, 1, 0, 0); cyc();
        check("pe_err", 32'(bus.resolve_err_o), 1);
        check("pe_count", 32'(bus.count_o), 1);
        for (int i = 0; i < 7; i++) begin drv(1, iw'(40 + i), 0, 0, 0, 0); cyc(); end
        drv(1, 9'h55, 0, 1, 1, 0); cyc();
        check("fullpp_count", 32'(bus.count_o), 7);
        check("fullpp_idx", 32'(bus.idx_w_o), 32'h07);
        drv(1, 9'h66, 1, 1, 1, 1); cyc();
        check("flush2_idx", 32'(bus.idx_w_o), 40);
        drv(1, 9'h77, 1, 0, 0, 0); cyc();
        drv(1, 9'h78, 1, 1, 0, 0); reset_n_i = 1'b0; cyc();
        check("rst2_count", 32'(bus.count_o), 0);
        check("rst2_idx", 32'(bus.idx_w_o), 0);
        reset_n_i = 1'b1;
        drv(0, 0, 0, 0, 0, 0); cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
